// File: rtl/ram_dma_engine.sv
// ram_dma_engine
//
// Block-transfer initiator for one port of a single-port synchronous RAM.
// The RAM has registered read data with one cycle of read latency.
// On a start strobe in IDLE the engine runs one of two transfers:
//   - copy: moves len words from src to dst, taking 2 cycles per word (RD then WR);
//   - fill: writes a constant to len words starting at dst, 1 cycle per word.
// Both pointers wrap modulo 1<<A. A len of 0 goes straight to DONE and
// performs no RAM access.
//
// Ports
//   clk       in   clock; all state changes on posedge
//   reset_n   in   synchronous active-low reset
//   start     in   command strobe, sampled only in IDLE
//   mode      in   0 = copy, 1 = fill
//   src       in   [A-1:0] copy source start address
//   dst       in   [A-1:0] destination start address
//   len       in   [A:0]   transfer length in words, 0..(1<<A)
//   fill      in   [D-1:0] fill value
//   busy      out  high while a transfer is in progress
//   done      out  one-cycle completion pulse
//   mem_addr  out  [A-1:0] RAM address
//   mem_din   out  [D-1:0] RAM write data
//   mem_we    out  RAM write enable
//   mem_dout  in   [D-1:0] RAM registered read data
//
// Handshake: start is a level sampled on the posedge while the engine is
// in IDLE. It is ignored in every other state. Once a command is accepted,
// its fields are held in internal registers, so later changes on the
// inputs do not affect it. done is high for exactly one cycle, and busy is
// never high in that same cycle.

module ram_dma_engine #(
    parameter int A = 10,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         mode,
    input  logic [A-1:0] src,
    input  logic [A-1:0] dst,
    input  logic [A:0]   len,
    input  logic [D-1:0] fill,
    output logic         busy,
    output logic         done,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_din,
    output logic         mem_we,
    input  logic [D-1:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FILL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [A:0] COUNT_ONE = {{A{1'b0}}, 1'b1};

    state_t       state;
    state_t       state_next;
    logic [A-1:0] src_ptr;
    logic [A-1:0] dst_ptr;
    logic [A:0]   count;
    logic [D-1:0] fill_q;

    // The copy/fill mode is not kept in a separate register. It is encoded
    // by the state that IDLE branches to: RD for a copy, FILL for a fill.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            fill_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        count   <= len;
                        fill_q  <= fill;
                    end
                end
                S_WR: begin
                    src_ptr <= src_ptr + 1'b1;
                    dst_ptr <= dst_ptr + 1'b1;
                    count   <= count - 1'b1;
                end
                S_FILL: begin
                    dst_ptr <= dst_ptr + 1'b1;
                    count   <= count - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = fill_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_next = S_DONE;
                    end else if (mode) begin
                        state_next = S_FILL;
                    end else begin
                        state_next = S_RD;
                    end
                end
            end
            S_RD: begin
                busy       = 1'b1;
                mem_addr   = src_ptr;
                state_next = S_WR;
            end
            S_WR: begin
                // The word addressed in RD arrives on mem_dout during this
                // cycle. It is passed straight through to the write port.
                busy       = 1'b1;
                mem_addr   = dst_ptr;
                mem_we     = 1'b1;
                mem_din    = mem_dout;
                state_next = (count == COUNT_ONE) ? S_DONE : S_RD;
            end
            S_FILL: begin
                busy       = 1'b1;
                mem_addr   = dst_ptr;
                mem_we     = 1'b1;
                state_next = (count == COUNT_ONE) ? S_DONE : S_FILL;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_dma_engine.sv
// Self-checking bench for ram_dma_engine.
// It contains a behavioural single-port RAM with registered read data, and
// directed scenarios whose expected values are computed by hand.

module tb_ram_dma_engine;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       mode;
    logic [9:0] src;
    logic [9:0] dst;
    logic [10:0] len;
    logic [7:0] fill;
    logic       busy;
    logic       done;
    logic [9:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_we;
    logic [7:0] mem_dout;

    // Bench-side preload port into the RAM model.
    logic       bd_we;
    logic [9:0] bd_addr;
    logic [7:0] bd_data;

    logic [7:0] ram [0:1023];

    int pass_cnt;
    int total_cnt;

    ram_dma_engine #(.A(10), .D(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill     (fill),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_we === 1'b1) begin
            ram[mem_addr] <= mem_din;
        end
        mem_dout <= ram[mem_addr];
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_addr = i[9:0];
            bd_data = 8'h00;
        end
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Drives a command across one posedge (T0). Returns at the negedge of cycle 1.
    task automatic issue(input logic m, input logic [9:0] s, input logic [9:0] d,
                         input logic [10:0] l, input logic [7:0] f);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        src   = s;
        dst   = d;
        len   = l;
        fill  = f;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples from cycle 1 onwards, until done is seen or max_cyc cycles pass.
    task automatic wait_finish(input int max_cyc, output int done_cyc, output int busy_cnt,
                               output int we_cnt, output int both_cnt);
        done_cyc = -1;
        busy_cnt = 0;
        we_cnt   = 0;
        both_cnt = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            if (busy === 1'b1 && done === 1'b1) both_cnt++;
            if (mem_we === 1'b1) we_cnt++;
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, mem_we} !== 3'b000) $display("FAIL reset_ctrl: got %b required 000", {busy, done, mem_we});
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 10'h000) $display("FAIL reset_addr: got %h required 000", mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (mem_din !== 8'h00) $display("FAIL reset_din: got %h required 00", mem_din);
        else pass_cnt++;
        reset_n = 1'b1;
    endtask

    task automatic test_reset_mid_fill();
        int we_after;
        issue(1'b1, 10'h000, 10'h100, 11'd64, 8'hC3);
        repeat (9) @(negedge clk);          // now in cycle 10, the write to 0x109 is pending
        reset_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, mem_we} !== 3'b000 || mem_addr !== 10'h000)
            $display("FAIL midreset_out: got busy/done/we=%b addr=%h required 000 addr=000",
                     {busy, done, mem_we}, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        we_after = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_we === 1'b1 || busy === 1'b1 || done === 1'b1) we_after++;
        end
        total_cnt++;
        if (we_after !== 0) $display("FAIL midreset_quiet: got %0d active cycles required 0", we_after);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h100] !== 8'hC3 || ram[10'h109] !== 8'hC3)
            $display("FAIL midreset_written: got %h/%h required c3/c3", ram[10'h100], ram[10'h109]);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h10A] !== 8'h00 || ram[10'h13F] !== 8'h00)
            $display("FAIL midreset_untouched: got %h/%h required 00/00", ram[10'h10A], ram[10'h13F]);
        else pass_cnt++;
    endtask

    task automatic test_fill_wrap();
        int dc, bc, wc, bo, bad;
        logic [9:0] a;
        issue(1'b1, 10'h000, 10'h3F0, 11'd32, 8'hA5);
        wait_finish(100, dc, bc, wc, bo);
        total_cnt++;
        if (dc !== 33) $display("FAIL fill_done_cycle: got %0d required 33", dc);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 32 || wc !== 32 || bo !== 0)
            $display("FAIL fill_counts: got busy=%0d we=%0d both=%0d required 32/32/0", bc, wc, bo);
        else pass_cnt++;
        bad = 0;
        a = 10'h3F0;
        for (int i = 0; i < 32; i++) begin
            if (ram[a] !== 8'hA5) bad++;
            a = a + 10'd1;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL fill_data: got %0d wrong words required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h010] !== 8'h00 || ram[10'h3EF] !== 8'h00)
            $display("FAIL fill_bounds: got %h/%h required 00/00", ram[10'h010], ram[10'h3EF]);
        else pass_cnt++;
    endtask

    task automatic test_copy();
        int dc, bc, wc, bo, bad;
        for (int i = 0; i < 16; i++) preload(i[9:0], i[7:0]);
        issue(1'b0, 10'h000, 10'h200, 11'd16, 8'hFF);
        wait_finish(100, dc, bc, wc, bo);
        total_cnt++;
        if (dc !== 33) $display("FAIL copy_done_cycle: got %0d required 33", dc);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 32 || wc !== 16 || bo !== 0)
            $display("FAIL copy_counts: got busy=%0d we=%0d both=%0d required 32/16/0", bc, wc, bo);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 16; i++) if (ram[10'h200 + i[9:0]] !== i[7:0]) bad++;
        total_cnt++;
        if (bad !== 0) $display("FAIL copy_data: got %0d wrong words required 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h210] !== 8'h00) $display("FAIL copy_bound: got %h required 00", ram[10'h210]);
        else pass_cnt++;
    endtask

    task automatic test_overlap();
        int dc, bc, wc, bo;
        preload(10'h010, 8'h11);
        preload(10'h011, 8'h22);
        issue(1'b0, 10'h010, 10'h011, 11'd4, 8'h00);
        wait_finish(50, dc, bc, wc, bo);
        total_cnt++;
        if (dc !== 9) $display("FAIL overlap_done_cycle: got %0d required 9", dc);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h011] !== 8'h11 || ram[10'h012] !== 8'h11 || ram[10'h013] !== 8'h11 || ram[10'h014] !== 8'h11)
            $display("FAIL overlap_data: got %h %h %h %h required 11 11 11 11",
                     ram[10'h011], ram[10'h012], ram[10'h013], ram[10'h014]);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h015] !== 8'h00) $display("FAIL overlap_bound: got %h required 00", ram[10'h015]);
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        int dc, bc, wc, bo;
        issue(1'b1, 10'h000, 10'h050, 11'd0, 8'h99);
        wait_finish(20, dc, bc, wc, bo);
        total_cnt++;
        if (dc !== 1) $display("FAIL len0_done_cycle: got %0d required 1", dc);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 0 || wc !== 0 || ram[10'h050] !== 8'h00)
            $display("FAIL len0_quiet: got busy=%0d we=%0d ram=%h required 0/0/00", bc, wc, ram[10'h050]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int done1, done2, busy11;
        for (int i = 0; i < 4; i++) preload(10'h020 + i[9:0], 8'h40 + i[7:0]);
        issue(1'b0, 10'h020, 10'h300, 11'd4, 8'h00);
        done1 = -1;
        done2 = -1;
        busy11 = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1) begin
                if (done1 < 0) done1 = k;
                else if (done2 < 0) done2 = k;
            end
            if (k == 11) busy11 = (busy === 1'b1) ? 1 : 0;
            case (k)
                3, 9: begin
                    start = 1'b1; mode = 1'b1; src = 10'h000; dst = 10'h380; len = 11'd2; fill = 8'hEE;
                end
                10: begin
                    start = 1'b1; mode = 1'b1; src = 10'h000; dst = 10'h3A0; len = 11'd2; fill = 8'h77;
                end
                default: start = 1'b0;
            endcase
            @(negedge clk);
        end
        start = 1'b0;
        total_cnt++;
        if (done1 !== 9) $display("FAIL b2b_first_done: got %0d required 9", done1);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h300] !== 8'h40 || ram[10'h303] !== 8'h43 || ram[10'h304] !== 8'h00)
            $display("FAIL b2b_copy_data: got %h %h %h required 40 43 00", ram[10'h300], ram[10'h303], ram[10'h304]);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h380] !== 8'h00) $display("FAIL b2b_ignored_cmd: got %h required 00", ram[10'h380]);
        else pass_cnt++;
        total_cnt++;
        if (busy11 !== 1 || done2 !== 13) $display("FAIL b2b_second_cmd: got busy=%0d done=%0d required 1/13", busy11, done2);
        else pass_cnt++;
        total_cnt++;
        if (ram[10'h3A0] !== 8'h77 || ram[10'h3A1] !== 8'h77 || ram[10'h3A2] !== 8'h00)
            $display("FAIL b2b_second_data: got %h %h %h required 77 77 00", ram[10'h3A0], ram[10'h3A1], ram[10'h3A2]);
        else pass_cnt++;
    endtask

    task automatic test_full_fill();
        int dc, bc, wc, bo, bad;
        issue(1'b1, 10'h000, 10'h123, 11'd1024, 8'h5A);
        wait_finish(1100, dc, bc, wc, bo);
        total_cnt++;
        if (dc !== 1025) $display("FAIL full_done_cycle: got %0d required 1025", dc);
        else pass_cnt++;
        total_cnt++;
        if (wc !== 1024 || bo !== 0) $display("FAIL full_counts: got we=%0d both=%0d required 1024/0", wc, bo);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== 8'h5A) bad++;
        total_cnt++;
        if (bad !== 0) $display("FAIL full_data: got %0d wrong words required 0", bad);
        else pass_cnt++;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        src       = '0;
        dst       = '0;
        len       = '0;
        fill      = '0;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_data   = '0;
        test_reset();
        clear_ram();
        test_reset_mid_fill();
        test_fill_wrap();
        test_copy();
        test_overlap();
        test_len_zero();
        test_back_to_back();
        test_full_fill();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ram_dma_engine.md
# ram_dma_engine

Block-transfer initiator that masters the address/data/write-enable port of a single-port synchronous RAM with registered read data and a one-cycle read latency. It performs either a byte copy (source region to destination region) or a constant fill (value to destination region) on command, so the CPU can offload video/sprite memory setup. It sits between the system control logic (start/busy/done) and one RAM port.

## Interface
- A, 10, number of RAM address bits
- D, 8, number of RAM data bits
- clk  in  1  clock; all state changes on posedge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src  in  A  copy source start address (ignored in fill)
- dst  in  A  destination start address
- len  in  A+1  transfer length in words, 0..(1<<A)
- fill  in  D  fill value (ignored in copy)
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle completion pulse
- mem_addr  out  A  RAM address
- mem_din  out  D  RAM write data
- mem_we  out  1  RAM write enable
- mem_dout  in  D  RAM registered read data (valid the cycle after the address was presented)

## Operation
- Reset (reset_n low at a posedge): state IDLE; busy=0, done=0, mem_we=0, mem_addr=0; internal fill/mode registers cleared so mem_din=0. Reset takes priority over everything, including mid-transfer; a transfer interrupted by reset is abandoned, no further writes.
- States: IDLE, RD, WR, FILL, DONE.
- IDLE: on start=1, latch src, dst, len, mode, fill into internal registers; remaining count = len.
  - len=0 -> DONE (no RAM access).
  - mode=0 -> RD; mode=1 -> FILL.
- RD: mem_addr=src_ptr, mem_we=0, busy=1. Next state WR.
- WR: mem_addr=dst_ptr, mem_we=1, mem_din=mem_dout (combinational pass-through of the word read in RD), busy=1. On exit: src_ptr+1, dst_ptr+1, count-1; count reaching 0 -> DONE, else RD.
- FILL: mem_addr=dst_ptr, mem_we=1, mem_din=latched fill, busy=1. Per cycle dst_ptr+1, count-1; count reaching 0 -> DONE.
- DONE: done=1, busy=0, mem_we=0 for exactly one cycle; next IDLE. start in DONE is ignored.
- mem_din outside WR: latched fill value; don't-care to the RAM since mem_we=0.
- Pointers are A bits and wrap modulo 1<<A (address (1<<A)-1 is followed by 0).
- len=(1<<A) is legal and touches every address once.
- Overlap: copy is strictly forward, word by word. dst in (src, src+len) propagates already-written data (pattern replication); this is the defined behaviour, not an error.
- start while busy or in DONE: ignored; input changes after acceptance have no effect.

## Timing
- Command accepted at posedge T0 (IDLE, start=1).
- Copy of N>0 words: RD/WR pairs occupy cycles 1..2N after T0; writes committed at posedges ending cycles 2,4,...,2N; done high in cycle 2N+1; IDLE in cycle 2N+2, new start accepted at the end of that cycle.
- Fill of N>0 words: writes in cycles 1..N; done in cycle N+1.
- len=0: done in cycle 1, busy never asserted, mem_we never asserted.
- busy and done are never high simultaneously; mem_we is high only in WR/FILL.
- Throughput: copy 2 cycles/word, fill 1 cycle/word.

## Test plan
- Reset: hold reset_n=0 for 2 cycles mid-fill (dst=0x100, len=64) -> the next cycle busy=0, done=0, mem_we=0, mem_addr=0; no further writes; memory beyond the last pre-reset write unchanged.
- Fill: mode=1, dst=0x3F0, len=32, fill=0xA5 -> addresses 0x3F0..0x3FF and 0x000..0x00F read 0xA5 (wrap); done exactly in cycle 33 after T0; 0x010 untouched.
- Copy: preload 0x000..0x00F with 0x00..0x0F; mode=0, src=0x000, dst=0x200, len=16 -> 0x200..0x20F = 0x00..0x0F; busy high for 32 cycles, done in cycle 33.
- Overlap: preload 0x10=0x11, 0x11=0x22; copy src=0x10, dst=0x11, len=4 -> 0x11..0x14 all 0x11.
- Edge lengths: len=0 -> done in cycle 1, no mem_we; fill with len=1024, fill=0x5A -> all 1024 words 0x5A, done in cycle 1025.
- Command hygiene: pulse start again at cycles 3 and 2N+1 of a copy with changed src/len -> ignored, original transfer results only; start at cycle 2N+2 is accepted.
